// File: rtl/ttr_recovery_ctrl_pkg.sv
// ttr_pkg: shared state encoding, slot codes and width helper for the TTR recovery sequencer
package ttr_pkg;
  typedef enum logic [1:0] {NOM, RED, REC, HALT} ttrState;
  localparam logic [1:0] CTR_S0 = 2'b00;
  localparam logic [1:0] CTR_S1 = 2'b01;
  localparam logic [1:0] CTR_S2 = 2'b10;
  localparam int REC_CYCLES_DEF = 4;
  localparam int TMR_W_DEF = $clog2(REC_CYCLES_DEF + 1);
  function automatic int cntW(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ttr_recovery_ctrl_if.sv
// ttr_recovery_ctrl_if: request/status bundle between the TTR sequencer (slave) and its user (master)
//   userMode, fail             : requests into the sequencer
//   ctr, modeS, recover,
//   userFail, errCnt           : sequencer status outputs
interface ttr_recovery_ctrl_if #(parameter int ERR_W = 8);
  logic userMode;
  logic fail;
  logic [1:0] ctr;
  logic modeS;
  logic recover;
  logic userFail;
  logic [ERR_W-1:0] errCnt;
  modport master(output userMode, fail, input ctr, modeS, recover, userFail, errCnt);
  modport slave(input userMode, fail, output ctr, modeS, recover, userFail, errCnt);
endinterface

// File: rtl/ttr_sat_cnt.sv
// ttr_sat_cnt: up counter that sticks at all-ones; clr has priority over inc
//   clk, reset : clock, async active-high reset
//   inc, clr   : count enable, synchronous clear
//   q          : count value
module ttr_sat_cnt #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= clr ? '0 : (inc && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/ttr_recovery_ctrl.sv
// ttr_recovery_ctrl: frame-aligned TTR mode switching with bounded rollback/recovery
//   clk, reset : clock, async active-high reset
//   bus        : userMode/fail in; ctr, modeS, recover, userFail, errCnt out (all registered)
module ttr_recovery_ctrl
  import ttr_pkg::*;
#(
  parameter int REC_CYCLES = REC_CYCLES_DEF,
  parameter int MAX_RETRY  = 3,
  parameter int ERR_W      = 8
) (
  input logic clk,
  input logic reset,
  ttr_recovery_ctrl_if.slave bus
);
  localparam int TW = cntW(REC_CYCLES);
  localparam int RW = cntW(MAX_RETRY);
  ttrState state, nState;
  logic [1:0] nCtr;
  logic nModeS;
  logic [TW-1:0] timer, nTimer;
  logic [RW-1:0] retry;
  logic retryInc, retryClr, errInc, lastTry;
  // a fail that would bring retry up to MAX_RETRY halts instead of recovering
  assign lastTry = int'(retry) + 1 >= MAX_RETRY;
  ttr_sat_cnt #(.W(RW)) retryCnt (.clk(clk), .reset(reset), .inc(retryInc), .clr(retryClr), .q(retry));
  ttr_sat_cnt #(.W(ERR_W)) errCntr (.clk(clk), .reset(reset), .inc(errInc), .clr(1'b0), .q(bus.errCnt));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= NOM;
      timer        <= '0;
      bus.ctr      <= CTR_S0;
      bus.modeS    <= 1'b0;
      bus.recover  <= 1'b0;
      bus.userFail <= 1'b0;
    end else begin
      state        <= nState;
      timer        <= nTimer;
      bus.ctr      <= nCtr;
      bus.modeS    <= nModeS;
      bus.recover  <= nState == REC;
      bus.userFail <= nState == HALT;
    end
  always_comb begin
    nState   = state;
    nCtr     = CTR_S0;
    nModeS   = bus.modeS;
    nTimer   = timer;
    retryInc = 1'b0;
    retryClr = 1'b0;
    errInc   = 1'b0;
    unique case (state)
      NOM: begin
        nModeS = 1'b0;
        if (bus.fail) nState = HALT;
        else if (bus.userMode) begin
          nState = RED;
          nModeS = 1'b1;
        end
      end
      RED: begin
        if (bus.fail) begin
          nState   = lastTry ? HALT : REC;
          nTimer   = '0;
          retryInc = !lastTry;
          errInc   = !lastTry;
        end else if (bus.ctr == CTR_S2) begin
          // frame boundary: only here may the mode drop back to nominal
          retryClr = 1'b1;
          nState   = bus.userMode ? RED : NOM;
          nModeS   = bus.userMode;
        end else nCtr = bus.ctr == CTR_S0 ? CTR_S1 : CTR_S2;
      end
      REC: begin
        nState = timer == TW'(REC_CYCLES - 1) ? RED : REC;
        nTimer = timer + 1'b1;
      end
      HALT: nState = HALT;
    endcase
  end
endmodule

// File: tb/tb_ttr_recovery_ctrl.sv
// tb_ttr_recovery_ctrl: directed self-checking bench for the TTR recovery sequencer
module tb_ttr_recovery_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ttr_recovery_ctrl_if #(.ERR_W(8)) bus ();
  ttr_recovery_ctrl_if #(.ERR_W(2)) bus2 ();
  assign bus2.userMode = bus.userMode;
  assign bus2.fail = bus.fail;
  ttr_recovery_ctrl #(.REC_CYCLES(4), .MAX_RETRY(3), .ERR_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  ttr_recovery_ctrl #(.REC_CYCLES(4), .MAX_RETRY(3), .ERR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input logic [1:0] ctrE, input logic modeE, input logic recE,
                    input logic ufE, input int errE);
    chk(tag, {27'b0, bus.ctr, bus.modeS, bus.recover, bus.userFail}, {27'b0, ctrE, modeE, recE, ufE});
    chk({tag, "_errCnt"}, 32'(bus.errCnt), errE);
  endtask
  task automatic recWin(input string tag, input int errE);
    st({tag, "_c1"}, 2'b00, 1'b1, 1'b1, 1'b0, errE);
    tick(); st({tag, "_c2"}, 2'b00, 1'b1, 1'b1, 1'b0, errE);
    tick(); st({tag, "_c3"}, 2'b00, 1'b1, 1'b1, 1'b0, errE);
    tick(); st({tag, "_c4"}, 2'b00, 1'b1, 1'b1, 1'b0, errE);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.userMode = 1'b0;
    bus.fail = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) begin
      tick(); st("t1_idle", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    end
    bus.fail = 1'b1;
    tick(); bus.fail = 1'b0;
    st("nom_fail_halt", 2'b00, 1'b0, 1'b0, 1'b1, 0);
    bus.userMode = 1'b1;
    tick(); tick(); st("halt_hold", 2'b00, 1'b0, 1'b0, 1'b1, 0);
    bus.userMode = 1'b0;
    reset = 1'b1;
    tick(); st("rst_from_halt", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick();
    bus.userMode = 1'b1;
    tick(); st("t2_s0", 2'b00, 1'b1, 1'b0, 1'b0, 0);
    tick(); st("t2_s1", 2'b01, 1'b1, 1'b0, 1'b0, 0);
    tick(); st("t2_s2", 2'b10, 1'b1, 1'b0, 1'b0, 0);
    tick(); st("t2_s0b", 2'b00, 1'b1, 1'b0, 1'b0, 0);
    tick(); st("t2_s1b", 2'b01, 1'b1, 1'b0, 1'b0, 0);
    bus.userMode = 1'b0;
    tick(); st("t3_deferred", 2'b10, 1'b1, 1'b0, 1'b0, 0);
    tick(); st("t3_nom", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    tick(); st("t3_nom_hold", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    bus.userMode = 1'b1;
    tick(); st("t4_s0", 2'b00, 1'b1, 1'b0, 1'b0, 0);
    tick(); st("t4_s1", 2'b01, 1'b1, 1'b0, 1'b0, 0);
    bus.fail = 1'b1;
    bus.userMode = 1'b0;
    tick(); bus.fail = 1'b0;
    recWin("t4_rec", 1);
    tick(); st("t4_resume_s0", 2'b00, 1'b1, 1'b0, 1'b0, 1);
    tick(); st("t4_resume_s1", 2'b01, 1'b1, 1'b0, 1'b0, 1);
    tick(); st("t4_resume_s2", 2'b10, 1'b1, 1'b0, 1'b0, 1);
    tick(); st("t4_clean_nom", 2'b00, 1'b0, 1'b0, 1'b0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.userMode = 1'b1;
    tick(); st("t5_red", 2'b00, 1'b1, 1'b0, 1'b0, 0);
    bus.fail = 1'b1;
    tick(); bus.fail = 1'b0;
    recWin("t5_rec1", 1);
    tick(); st("t5_red1", 2'b00, 1'b1, 1'b0, 1'b0, 1);
    bus.fail = 1'b1;
    tick(); bus.fail = 1'b0;
    recWin("t5_rec2", 2);
    tick(); st("t5_red2_s0", 2'b00, 1'b1, 1'b0, 1'b0, 2);
    tick(); st("t5_red2_s1", 2'b01, 1'b1, 1'b0, 1'b0, 2);
    tick(); st("t5_red2_s2", 2'b10, 1'b1, 1'b0, 1'b0, 2);
    bus.fail = 1'b1;
    tick(); bus.fail = 1'b0;
    st("t5_halt", 2'b00, 1'b1, 1'b0, 1'b1, 2);
    bus.userMode = 1'b0;
    tick(); bus.fail = 1'b1;
    tick(); bus.fail = 1'b0;
    tick(); st("t5_halt_sticky", 2'b00, 1'b1, 1'b0, 1'b1, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.userMode = 1'b1;
    tick(); st("t6_red", 2'b00, 1'b1, 1'b0, 1'b0, 0);
    bus.fail = 1'b1;
    tick(); bus.fail = 1'b0;
    tick(); st("t6_rec_c2", 2'b00, 1'b1, 1'b1, 1'b0, 1);
    reset = 1'b1;
    #1; st("t6_rst_async", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    bus.userMode = 1'b0;
    tick(); st("t6_rst_edge", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick(); st("t6_after_rst", 2'b00, 1'b0, 1'b0, 1'b0, 0);
    bus.userMode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.fail = 1'b1;
      tick(); bus.fail = 1'b0;
      st("t6_sat_rec", 2'b00, 1'b1, 1'b1, 1'b0, i + 1);
      chk("t6_sat_errCnt_w2", 32'(bus2.errCnt), (i < 3) ? i + 1 : 3);
      repeat (4) tick();
      tick(); tick(); tick();
    end
    chk("t6_sat_final", 32'(bus2.errCnt), 3);
    chk("t6_sat_no_halt", 32'(bus2.userFail), 0);
    st("t6_w8_final", 2'b00, 1'b1, 1'b0, 1'b0, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
